// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and pipeline stall.
// Optional macro MULDIV_FAST_MULT_EN: single-cycle combinational multiply; divides stay iterative.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] acc, qreg, breg;
    logic             div_q, neg_a, neg_b;

    logic             in_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign in_signed = ~op[0];
    assign abs_a = (in_signed & operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign abs_b = (in_signed & operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Multiply step: acc:qreg is the running product, qreg[0] selects the add.
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] m_acc_nx, m_q_nx;
    assign msum     = {1'b0, acc} + (qreg[0] ? {1'b0, breg} : '0);
    assign m_acc_nx = msum[WIDTH:1];
    assign m_q_nx   = {msum[0], qreg[WIDTH-1:1]};

    // Restoring divide step: acc is the partial remainder, qreg shifts dividend out / quotient in.
    logic [WIDTH:0]   rs, diff;
    logic [WIDTH-1:0] d_acc_nx, d_q_nx;
    assign rs       = {acc, qreg[WIDTH-1]};
    assign diff     = rs - {1'b0, breg};
    assign d_acc_nx = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
    assign d_q_nx   = {qreg[WIDTH-2:0], ~diff[WIDTH]};

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod     = {m_acc_nx, m_q_nx};
    assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_fix  = (neg_a ^ neg_b) ? -d_q_nx : d_q_nx;
    assign rem_fix  = neg_a ? -d_acc_nx : d_acc_nx;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{in_signed & operand_a[WIDTH-1]}}, operand_a}
                     * {{WIDTH{in_signed & operand_b[WIDTH-1]}}, operand_b};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            acc     <= '0;
            qreg    <= '0;
            breg    <= '0;
            div_q   <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (!cancel && start) begin
                        acc     <= '0;
                        qreg    <= abs_a;
                        breg    <= abs_b;
                        div_q   <= op[1];
                        neg_a   <= in_signed & operand_a[WIDTH-1];
                        neg_b   <= in_signed & operand_b[WIDTH-1];
                        counter <= '0;
`ifdef MULDIV_FAST_MULT_EN
                        if (!op[1]) begin
                            {hi, lo} <= fast_prod;
                            state    <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc     <= div_q ? d_acc_nx : m_acc_nx;
                        qreg    <= div_q ? d_q_nx : m_q_nx;
                        counter <= counter + 1'b1;
                        if (counter == LAST) begin
                            if (div_q) begin
                                hi <= rem_fix;
                                lo <= (breg == '0) ? '1 : quo_fix;
                            end else begin
                                {hi, lo} <= prod_fix;
                            end
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stall = (state == RUN) | ((state == IDLE) & start);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default iterative build).
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic        cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int n_assert = 0;
    int n_fail   = 0;
    int lat, sc, start_stall, done_seen;

    localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle; returns at the negedge after the sampling edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        #1 start_stall = int'(stall);
        @(negedge clock);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Counts negedges (after the start edge) until done, plus stalled cycles seen.
    task automatic wait_done(output int l, output int s);
        l = 0; s = start_stall;
        while (!done && l < 40) begin
            if (stall) s++;
            @(negedge clock);
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        launch(o, a, b);
        wait_done(lat, sc);
        chk({tag, "_lat"}, 32'(lat), 32'd32);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        @(negedge clock);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // MULTU with full latency/stall accounting
        launch(MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_start_stall", 32'(start_stall), 32'd1);
        wait_done(lat, sc);
        chk("multu_lat", 32'(lat), 32'd32);
        chk("multu_stall_cycles", 32'(sc), 32'd33);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        chk("multu_done_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        chk("multu_done_pulse", {31'd0, done}, 32'd0);
        chk("multu_idle", {31'd0, busy}, 32'd0);

        run("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("mult_m1m1", MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1);
        run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
        run("div_m7_2",  DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_7_m2",  DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
        run("divu_100_7", DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
        run("divu_by0",  DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFF_FFFF);
        run("div_by0",   DIV,   32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       32'h8000_0000);

        // MTHI / MTLO in IDLE
        @(negedge clock); hi_we = 1'b1; wd = 32'h1234;
        @(negedge clock); hi_we = 1'b0; lo_we = 1'b1; wd = 32'h5678;
        chk("mthi", hi, 32'h1234);
        @(negedge clock); lo_we = 1'b0;
        chk("mtlo", lo, 32'h5678);

        // MTLO during RUN ignored; start during RUN ignored
        launch(DIVU, 32'd100, 32'd7);
        lo_we = 1'b1; wd = 32'hDEAD_BEEF; start = 1'b1; op = MULTU; operand_a = 32'd3; operand_b = 32'd3;
        @(negedge clock);
        lo_we = 1'b0; start = 1'b0;
        chk("mtlo_in_run", lo, 32'h5678);
        wait_done(lat, sc);
        chk("norelatch_lat", 32'(lat + 1), 32'd32);
        chk("norelatch_hi", hi, 32'd2);
        chk("norelatch_lo", lo, 32'd14);

        // MTHI together with start: write lands, then result overwrites
        @(negedge clock); hi_we = 1'b1; wd = 32'hAAAA;
        launch(MULTU, 32'd3, 32'd4);
        chk("mthi_with_start", hi, 32'hAAAA);
        wait_done(lat, sc);
        chk("mthi_overwritten_hi", hi, 32'd0);
        chk("mthi_overwritten_lo", lo, 32'd12);

        // cancel mid-RUN with HI/LO preloaded
        @(negedge clock); hi_we = 1'b1; lo_we = 1'b1; wd = 32'd5;
        @(negedge clock); hi_we = 1'b0; wd = 32'd6;
        @(negedge clock); lo_we = 1'b0;
        launch(MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_stall", {31'd0, stall}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clock);
        end
        chk("cancel_no_done", 32'(done_seen), 32'd0);
        chk("cancel_hi", hi, 32'd5);
        chk("cancel_lo", lo, 32'd6);

        // cancel beats start in IDLE
        @(negedge clock); start = 1'b1; cancel = 1'b1; op = MULTU;
        @(negedge clock); start = 1'b0; cancel = 1'b0;
        chk("cancel_idle_priority", {31'd0, busy}, 32'd0);

        // async reset mid-RUN, then a normal op
        launch(MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_stall", {31'd0, stall}, 32'd0);
        chk("rst_run_hi", hi, 32'd0);
        chk("rst_run_lo", lo, 32'd0);
        @(negedge clock); reset = 1'b0;
        run("after_rst", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
